booth_r4_seq_mult: RTL

//  Iterative radix-4 Booth multiplier. It retires one Booth digit per clock over a captured operand pair.

---
 rtl/booth_r4_seq_mult.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one Booth digit retired per clock,
// signed/unsigned selectable per operation, valid/ready on both sides.
module booth_r4_seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               signed_mode_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] product_o,
    output logic               busy_o
);

    localparam int NDIG = WIDTH / 2 + 1;
    localparam int EW   = WIDTH + 2;
    localparam int ACCW = 2 * WIDTH + 4;
    localparam int CW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ACCW-1:0]   mcand_q, mcand_d;
    logic [EW-1:0]     mplr_q, mplr_d;
    logic              prev_q, prev_d;
    logic [ACCW-1:0]   acc_q, acc_d;

    logic [2:0]        window;
    logic [ACCW-1:0]   pp_sel;
    logic [ACCW-1:0]   pp_ones;
    logic [ACCW-1:0]   pp_term;
    logic              pp_neg;
    logic [CW:0]       shamt;
    logic [ACCW-1:0]   acc_sum;
    logic [ACCW-1:0]   a_ext;
    logic [EW-1:0]     b_ext;

    // Operands are widened once at capture; unsigned mode zero-fills.
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        if (signed_mode_i) begin
            a_ext = {{(ACCW-WIDTH){a_i[WIDTH-1]}}, a_i};
            b_ext = {{2{b_i[WIDTH-1]}}, b_i};
        end else begin
            a_ext = {{(ACCW-WIDTH){1'b0}}, a_i};
            b_ext = {2'b00, b_i};
        end
    end

    // Booth recode of the current window; negation is ones' complement plus carry-in.
    always_comb begin
        window = {mplr_q[1], mplr_q[0], prev_q};
        pp_sel = '0;
        pp_neg = 1'b0;
        case (window)
            3'b001, 3'b010: pp_sel = mcand_q;
            3'b011:         pp_sel = mcand_q << 1;
            3'b100: begin
                pp_sel = mcand_q << 1;
                pp_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                pp_sel = mcand_q;
                pp_neg = 1'b1;
            end
            default:        pp_sel = '0;
        endcase
        pp_ones = pp_neg ? ~pp_sel : pp_sel;
        pp_term = pp_ones + {{(ACCW-1){1'b0}}, pp_neg};
        shamt   = {cnt_q, 1'b0};
        acc_sum = acc_q + (pp_term << shamt);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        prev_d  = prev_q;
        acc_d   = acc_q;
        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        mcand_d = a_ext;
                        mplr_d  = b_ext;
                        prev_d  = 1'b0;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    acc_d  = acc_sum;
                    mplr_d = mplr_q >> 2;
                    prev_d = mplr_q[1];
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(NDIG - 1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            prev_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            prev_q  <= prev_d;
            acc_q   <= acc_d;
        end
    end

    // Partial sums stay hidden until the last digit has been folded in.
    assign product_o   = (state_q == S_DONE) ? acc_q[2*WIDTH-1:0] : '0;
    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q == S_RUN) || (state_q == S_DONE);

endmodule
